barrel_motion: RTL and testbench
================================

BARREL_MOTION -- requirements
Module: barrel_motion

Interface
REQ-001 Parameter TICK_CYCLES, default 1666666, is the number of Clk cycles per motion step (30 Hz at 50 MHz).
REQ-002 Parameter X_LEFT, default 8'd0, is the leftmost roll column.
REQ-003 Parameter X_RIGHT, default 8'd150, is the rightmost roll column.
REQ-004 Parameter SPAWN_Y, default 7'd10, is the row of the top platform.
REQ-005 Parameter LEVEL_DY, default 7'd20, is the row drop between platforms.
REQ-006 Parameter NUM_LEVELS, default 5 (range 1..8), is the number of platforms.
REQ-007 Parameter RESPAWN_TICKS, default 30, is the number of steps the barrel stays off-screen between exit and respawn.
REQ-008 Clk  input  1  is the single system clock; all state updates on its rising edge.
REQ-009 ResetN  input  1  is the reset: asynchronous, active-low.
REQ-010 start  input  1  launches the first barrel while in IDLE; it is a level signal and is ignored in all other states.
REQ-011 freeze  input  1  freezes all motion state while high; it is driven by gameOver.
REQ-012 barrelX  output  8  is the barrel column, consumed by collision logic.
REQ-013 barrelY  output  7  is the barrel row, consumed by collision logic.
REQ-014 barrelActive  output  1  is high while the barrel is on screen.
REQ-015 barrelDir  output  1  is the roll direction: 0 = right, 1 = left.
REQ-016 barrelLevel  output  3  is the current platform index, where 0 is the top.
REQ-017 spawnPulse  output  1  is a one-cycle pulse on every spawn.
REQ-018 exitPulse  output  1  is a one-cycle pulse when the barrel leaves the bottom platform.

Function
REQ-019 Tick counter:
- Counts down from TICK_CYCLES-1 to 0, then reloads.
- tick is asserted in the cycle the counter equals 0 and freeze is low.
- While freeze is high, the counter holds.
REQ-020 States are IDLE, ROLL, FALL and RESPAWN; every transition and position change other than IDLE->ROLL occurs only on tick.
REQ-021 IDLE->ROLL on start=1, without waiting for tick. On entry:
- barrelX <= spawn X; barrelY <= SPAWN_Y.
- barrelDir <= 0; barrelLevel <= 0.
- barrelActive <= 1; spawnPulse = 1 for one cycle.
REQ-022 ROLL on tick:
- If the barrel is not at the edge in its direction (X_RIGHT when right, X_LEFT when left), barrelX moves one column in barrelDir.
- If it is at the edge and barrelLevel < NUM_LEVELS-1, the state goes to FALL with no X change and the fall counter is cleared.
REQ-023 ROLL on tick with the barrel at the edge and barrelLevel == NUM_LEVELS-1:
- State goes to RESPAWN.
- barrelActive <= 0; exitPulse = 1 for one cycle.
- The respawn counter is cleared.
REQ-024 FALL on tick:
- barrelY increments by 1 and the fall counter increments.
- On the tick that completes LEVEL_DY increments: barrelLevel increments, barrelDir inverts, and the state returns to ROLL.
REQ-025 RESPAWN on tick: the respawn counter increments; on the tick that completes RESPAWN_TICKS steps, the REQ-021 entry actions execute (spawnPulse fires) and the state goes to ROLL.
REQ-026 Whenever barrelActive = 0, barrelX = 8'hFF and barrelY = 7'h7F (parked off-screen so that no collision can occur).
REQ-027 barrelY arithmetic is 7-bit; the parameters are constrained so that SPAWN_Y + (NUM_LEVELS-1)*LEVEL_DY <= 119; no wrap is permitted.
REQ-028 If freeze and tick would coincide, freeze wins: no state or output changes, and pulses are not generated.
REQ-029 While freeze is high in IDLE, start is ignored.
REQ-030 spawnPulse and exitPulse are never high in the same cycle and never high for two consecutive cycles.

Reset
REQ-031 While ResetN = 0, immediately and independent of Clk:
- State = IDLE; tick counter = TICK_CYCLES-1; fall and respawn counters = 0.
- barrelX = 8'hFF; barrelY = 7'h7F; barrelActive = 0.
- barrelDir = 0; barrelLevel = 0; spawnPulse = 0; exitPulse = 0.
REQ-032 Reset asserted mid-roll, mid-fall or mid-respawn aborts the motion with no exitPulse; after release, the block waits in IDLE for start.

Configuration
REQ-033 With BARREL_LFSR_SPAWN_EN defined:
- An 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded 8'hA5 at reset, advances every Clk cycle in which freeze is low.
- Spawn X = X_LEFT + lfsr[4:0], sampled at the spawn cycle.
REQ-034 Without BARREL_LFSR_SPAWN_EN, spawn X = X_LEFT and no LFSR is instantiated.

Verification (TICK_CYCLES=4, X_LEFT=0, X_RIGHT=5, SPAWN_Y=10, LEVEL_DY=3, NUM_LEVELS=2, RESPAWN_TICKS=2, macro off)
REQ-035 Reset release, then start pulse -> next edge: X=0, Y=10, barrelActive=1, spawnPulse=1 for one cycle; X=5 after 5 ticks (20 cycles).
REQ-036 Continuing from REQ-035 -> tick 6 enters FALL with X=5; Y goes 11,12,13 on ticks 7-9; tick 9 gives barrelLevel=1, barrelDir=1; X=0 after 5 more ticks.
REQ-037 Continuing from REQ-036 -> next tick at X=0: exitPulse=1, barrelActive=0, X=FF, Y=7F; after 2 ticks, respawn at X=0, Y=10, barrelLevel=0, spawnPulse=1.
REQ-038 freeze=1 held for 40 cycles mid-roll at X=3 -> X stays 3 and no pulses; after release, X=4 exactly 1 tick later, preserving the residual counter phase.
REQ-039 ResetN=0 asynchronously mid-fall at Y=12 -> outputs take reset values before the next Clk edge; after release, with start held low, the barrel remains parked.
REQ-040 Macro on, start in the first cycle after reset -> spawn X = lfsr[4:0] of the seeded sequence at that cycle, within the range 0..31.

Source files
------------

// File: rtl/barrel_motion.sv
// Barrel motion controller: rolls a barrel across stacked platforms, drops it between them and respawns it after it exits.
// Optional feature: define BARREL_LFSR_SPAWN_EN to randomise the spawn column with an 8-bit LFSR.
module barrel_motion #(
  parameter int unsigned TICK_CYCLES   = 1666666,
  parameter logic [7:0]  X_LEFT        = 8'd0,
  parameter logic [7:0]  X_RIGHT       = 8'd150,
  parameter logic [6:0]  SPAWN_Y       = 7'd10,
  parameter logic [6:0]  LEVEL_DY      = 7'd20,
  parameter int unsigned NUM_LEVELS    = 5,
  parameter int unsigned RESPAWN_TICKS = 30
) (
  input  logic       Clk,
  input  logic       ResetN,
  input  logic       start,
  input  logic       freeze,
  output logic [7:0] barrelX,
  output logic [6:0] barrelY,
  output logic       barrelActive,
  output logic       barrelDir,
  output logic [2:0] barrelLevel,
  output logic       spawnPulse,
  output logic       exitPulse
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int RW = $clog2(RESPAWN_TICKS + 1);
  localparam logic [2:0] LAST_LEVEL = 3'(NUM_LEVELS - 1);
  localparam logic [7:0] PARK_X = 8'hFF;
  localparam logic [6:0] PARK_Y = 7'h7F;

  typedef enum logic [1:0] {IDLE, ROLL, FALL, RESPAWN} state_t;

  state_t          state, state_n;
  logic [TW-1:0]   tick_cnt;
  logic [6:0]      fall_cnt, fall_n;
  logic [RW-1:0]   resp_cnt, resp_n;
  logic [7:0]      x_n, spawn_x;
  logic [6:0]      y_n;
  logic            act_n, dir_n, sp_n, ep_n, do_spawn;
  logic [2:0]      lvl_n;
  logic            tick, at_edge;

  // Tick counter holds its residual phase while frozen, so motion resumes on the same cadence.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN)
      tick_cnt <= TW'(TICK_CYCLES - 1);
    else if (!freeze)
      tick_cnt <= (tick_cnt == '0) ? TW'(TICK_CYCLES - 1) : tick_cnt - TW'(1);
  end

  assign tick    = (tick_cnt == '0) && !freeze;
  assign at_edge = barrelDir ? (barrelX == X_LEFT) : (barrelX == X_RIGHT);

`ifdef BARREL_LFSR_SPAWN_EN
  logic [7:0] lfsr;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN)
      lfsr <= 8'hA5;
    else if (!freeze)
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign spawn_x = X_LEFT + {3'b000, lfsr[4:0]};
`else
  assign spawn_x = X_LEFT;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_n  = state;
    x_n      = barrelX;
    y_n      = barrelY;
    act_n    = barrelActive;
    dir_n    = barrelDir;
    lvl_n    = barrelLevel;
    fall_n   = fall_cnt;
    resp_n   = resp_cnt;
    sp_n     = 1'b0;
    ep_n     = 1'b0;
    do_spawn = 1'b0;

    unique case (state)
      IDLE: if (start && !freeze) do_spawn = 1'b1;
      ROLL: if (tick) begin
        if (!at_edge) begin
          x_n = barrelDir ? barrelX - 8'd1 : barrelX + 8'd1;
        end else if (barrelLevel != LAST_LEVEL) begin
          state_n = FALL;
          fall_n  = '0;
        end else begin
          state_n = RESPAWN;
          act_n   = 1'b0;
          x_n     = PARK_X;
          y_n     = PARK_Y;
          ep_n    = 1'b1;
          resp_n  = '0;
        end
      end
      FALL: if (tick) begin
        y_n    = barrelY + 7'd1;
        fall_n = fall_cnt + 7'd1;
        if (fall_cnt == LEVEL_DY - 7'd1) begin
          lvl_n   = barrelLevel + 3'd1;
          dir_n   = ~barrelDir;
          state_n = ROLL;
        end
      end
      RESPAWN: if (tick) begin
        resp_n = resp_cnt + RW'(1);
        if (resp_cnt == RW'(RESPAWN_TICKS - 1)) do_spawn = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    // Spawn entry actions are shared by the first launch and every respawn.
    if (do_spawn) begin
      state_n = ROLL;
      x_n     = spawn_x;
      y_n     = SPAWN_Y;
      dir_n   = 1'b0;
      lvl_n   = 3'd0;
      act_n   = 1'b1;
      sp_n    = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state        <= IDLE;
      fall_cnt     <= '0;
      resp_cnt     <= '0;
      barrelX      <= PARK_X;
      barrelY      <= PARK_Y;
      barrelActive <= 1'b0;
      barrelDir    <= 1'b0;
      barrelLevel  <= 3'd0;
      spawnPulse   <= 1'b0;
      exitPulse    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state        <= state_n;
      fall_cnt     <= fall_n;
      resp_cnt     <= resp_n;
      barrelX      <= x_n;
      barrelY      <= y_n;
      barrelActive <= act_n;
      barrelDir    <= dir_n;
      barrelLevel  <= lvl_n;
      spawnPulse   <= sp_n;
      exitPulse    <= ep_n;
    end
  end

endmodule

// File: tb/tb_barrel_motion.sv
// Scoreboard bench for barrel_motion: expected output-change events are queued up front and a monitor pops one per change.
module tb_barrel_motion;

  logic       Clk, ResetN, start, freeze;
  logic [7:0] barrelX;
  logic [6:0] barrelY;
  logic       barrelActive, barrelDir, spawnPulse, exitPulse;
  logic [2:0] barrelLevel;

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic       act;
    logic       dir;
    logic [2:0] lvl;
    logic       sp;
    logic       ep;
  } obs_t;

  typedef struct {
    obs_t o;
    int   delta;
  } exp_t;

  exp_t sb[$];

  barrel_motion #(
    .TICK_CYCLES(4), .X_LEFT(8'd0), .X_RIGHT(8'd5), .SPAWN_Y(7'd10),
    .LEVEL_DY(7'd3), .NUM_LEVELS(2), .RESPAWN_TICKS(2)
  ) dut (
    .Clk(Clk), .ResetN(ResetN), .start(start), .freeze(freeze),
    .barrelX(barrelX), .barrelY(barrelY), .barrelActive(barrelActive),
    .barrelDir(barrelDir), .barrelLevel(barrelLevel),
    .spawnPulse(spawnPulse), .exitPulse(exitPulse)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic obs_t snap();
    return '{barrelX, barrelY, barrelActive, barrelDir, barrelLevel, spawnPulse, exitPulse};
  endfunction

  task automatic push(input logic [7:0] x, input logic [6:0] y, input logic act, input logic dir,
                      input logic [2:0] lvl, input logic sp, input logic ep, input int delta);
    exp_t e;
    e.o     = '{x, y, act, dir, lvl, sp, ep};
    e.delta = delta;
    sb.push_back(e);
  endtask

  function automatic logic cond(input int sel);
    case (sel)
      0:       return barrelX == 8'd3;
      1:       return exitPulse;
      default: return (barrelY == 7'd12) && barrelActive;
    endcase
  endfunction

  task automatic wait_for(input int sel, input string name, input int budget);
    int n = 0;
    while (!cond(sel) && n < budget) begin
      @(negedge Clk);
      n++;
    end
    if (!cond(sel)) check(name, 32'd0, 32'd1);
  endtask

  // Monitor: each change of the observed output bundle consumes one expected event.
  initial begin
    obs_t cur, prev;
    exp_t e;
    int   cyc = 0;
    wait (mon_en);
    prev = snap();
    forever begin
      @(negedge Clk);
      if (mon_en) begin
        cyc++;
        cur = snap();
        if (cur.sp || cur.ep) check("pulse_exclusive", 32'(cur.sp & cur.ep), 32'd0);
        if (cur != prev) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got %h, expected no change at %0t", cur, $time);
          end else begin
            e = sb.pop_front();
            check("event_outputs", 32'(cur), 32'(e.o));
            if (e.delta != 0) check("event_spacing", 32'(cyc), 32'(e.delta));
          end
          prev = cur;
          cyc  = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ResetN = 1'b1;
    start  = 1'b0;
    freeze = 1'b0;
    #1 ResetN = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_x",   32'(barrelX), 32'hFF);
    check("rst_y",   32'(barrelY), 32'h7F);
    check("rst_act", 32'(barrelActive), 32'd0);
    check("rst_dir", 32'(barrelDir), 32'd0);
    check("rst_lvl", 32'(barrelLevel), 32'd0);
    check("rst_sp",  32'(spawnPulse), 32'd0);
    check("rst_ep",  32'(exitPulse), 32'd0);

    // First barrel: spawn, roll right (with a 40-cycle freeze at X=3), fall, roll left, exit.
    push(8'd0, 7'd10, 1, 0, 0, 1, 0, 0);
    push(8'd0, 7'd10, 1, 0, 0, 0, 0, 1);
    push(8'd1, 7'd10, 1, 0, 0, 0, 0, 0);
    push(8'd2, 7'd10, 1, 0, 0, 0, 0, 4);
    push(8'd3, 7'd10, 1, 0, 0, 0, 0, 4);
    push(8'd4, 7'd10, 1, 0, 0, 0, 0, 44);
    push(8'd5, 7'd10, 1, 0, 0, 0, 0, 4);
    push(8'd5, 7'd11, 1, 0, 0, 0, 0, 8);
    push(8'd5, 7'd12, 1, 0, 0, 0, 0, 4);
    push(8'd5, 7'd13, 1, 1, 1, 0, 0, 4);
    for (int x = 4; x >= 0; x--) push(8'(x), 7'd13, 1, 1, 1, 0, 0, 4);
    push(8'hFF, 7'h7F, 0, 1, 1, 0, 1, 4);
    push(8'hFF, 7'h7F, 0, 1, 1, 0, 0, 1);
    // Respawned barrel rolls right and is reset mid-fall at Y=12.
    push(8'd0, 7'd10, 1, 0, 0, 1, 0, 7);
    push(8'd0, 7'd10, 1, 0, 0, 0, 0, 1);
    push(8'd1, 7'd10, 1, 0, 0, 0, 0, 3);
    for (int x = 2; x <= 5; x++) push(8'(x), 7'd10, 1, 0, 0, 0, 0, 4);
    push(8'd5, 7'd11, 1, 0, 0, 0, 0, 8);
    push(8'd5, 7'd12, 1, 0, 0, 0, 0, 4);
    push(8'hFF, 7'h7F, 0, 0, 0, 0, 0, 0);
    // Launch after the frozen-idle window.
    push(8'd0, 7'd10, 1, 0, 0, 1, 0, 0);
    push(8'd0, 7'd10, 1, 0, 0, 0, 0, 1);

    @(negedge Clk);
    ResetN = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;

    wait_for(0, "wait_x3", 200);
    @(negedge Clk);
    freeze = 1'b1;
    repeat (40) @(negedge Clk);
    freeze = 1'b0;

    wait_for(1, "wait_exit", 400);
    @(negedge Clk);
    wait_for(2, "wait_y12", 400);

    @(posedge Clk);
    #2 ResetN = 1'b0;
    #1;
    check("async_rst_x",   32'(barrelX), 32'hFF);
    check("async_rst_y",   32'(barrelY), 32'h7F);
    check("async_rst_act", 32'(barrelActive), 32'd0);
    check("async_rst_ep",  32'(exitPulse), 32'd0);
    repeat (3) @(negedge Clk);
    ResetN = 1'b1;

    repeat (30) @(negedge Clk);
    check("parked_after_reset_x", 32'(barrelX), 32'hFF);
    check("parked_after_reset_act", 32'(barrelActive), 32'd0);

    freeze = 1'b1;
    start  = 1'b1;
    repeat (12) @(negedge Clk);
    check("frozen_idle_act", 32'(barrelActive), 32'd0);
    freeze = 1'b0;
    @(negedge Clk);
    start  = 1'b0;
    freeze = 1'b1;
    repeat (5) @(negedge Clk);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
